// File: rtl/quad_pkg.sv
// Shared phase encodings, direction codes and the transition classifier
// used by the quadrature decoder.
package quad_pkg;

  typedef enum logic [1:0] {
    PH_00 = 2'b00,
    PH_01 = 2'b01,
    PH_11 = 2'b11,
    PH_10 = 2'b10
  } phase_e;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef struct packed {
    logic valid;
    logic up;
    logic illegal;
  } step_t;

  // Forward order is 00->01->11->10->00; a change of both bits at once is a double step.
  function automatic step_t decodePhase(input logic [1:0] prevPh, input logic [1:0] curPh);
    step_t res;
    res = '0;
    case ({prevPh, curPh})
      {PH_00, PH_01}, {PH_01, PH_11}, {PH_11, PH_10}, {PH_10, PH_00}: begin
        res.valid = 1'b1;
        res.up    = DIR_UP;
      end
      {PH_00, PH_10}, {PH_10, PH_11}, {PH_11, PH_01}, {PH_01, PH_00}: begin
        res.valid = 1'b1;
        res.up    = DIR_DN;
      end
      {PH_00, PH_11}, {PH_11, PH_00}, {PH_01, PH_10}, {PH_10, PH_01}: begin
        res.illegal = 1'b1;
      end
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/quad_decoder_bit_sync.sv
// Multi-flop synchronizer bringing one asynchronous board-level bit into the clk domain.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic sync_o
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], async_i};
    end
  end

  assign sync_o = chain_q[STAGES-1];

endmodule

// File: rtl/quad_decoder.sv
// Quadrature A/B decoder: synchronizes both phases, classifies each transition
// and maintains a wrapping position count, direction flag and sticky error flag.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic             quad_a,
  input  logic             quad_b,
  output logic [WIDTH-1:0] pos,
  output logic             dir,
  output logic             step,
  output logic             err
);

  localparam int ARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_INIT = ARM_W'(SYNC_STAGES + 1);

  logic             aSync, bSync;
  logic [1:0]       cur;
  logic [1:0]       prev_q, prev_d;
  logic [ARM_W-1:0] arm_q, arm_d;
  logic [WIDTH-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             err_q, err_d;
  step_t            dec;

  bit_sync #(.STAGES(SYNC_STAGES)) uSyncA (
    .clk    (clk),
    .reset  (reset),
    .async_i(quad_a),
    .sync_o (aSync)
  );

  bit_sync #(.STAGES(SYNC_STAGES)) uSyncB (
    .clk    (clk),
    .reset  (reset),
    .async_i(quad_b),
    .sync_o (bSync)
  );

  assign cur = {aSync, bSync};

  // Decoding stays masked until the synchronizers have flushed their reset
  // zeros, so the phase present at release is absorbed into prev, never counted.
  always_comb begin
    dec    = decodePhase(prev_q, cur);
    prev_d = cur;
    arm_d  = (arm_q != '0) ? arm_q - 1'b1 : arm_q;
    pos_d  = pos_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    err_d  = err_q;
    if (clear) begin
      pos_d = '0;
      err_d = 1'b0;
    end else if (arm_q == '0 && en) begin
      if (dec.valid) begin
        pos_d  = dec.up ? pos_q + WIDTH'(1) : pos_q - WIDTH'(1);
        dir_d  = dec.up;
        step_d = 1'b1;
      end else if (dec.illegal) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= PH_00;
      arm_q  <= ARM_INIT;
      pos_q  <= '0;
      dir_q  <= DIR_DN;
      step_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      arm_q  <= arm_d;
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      step_q <= step_d;
      err_q  <= err_d;
    end
  end

  assign pos  = pos_q;
  assign dir  = dir_q;
  assign step = step_q;
  assign err  = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed self-checking bench for quad_decoder with default parameters
// (WIDTH=8, SYNC_STAGES=2); outputs are sampled on the falling clock edge.
module tb_quad_decoder;

  logic       clk;
  logic       reset;
  logic       en;
  logic       clear;
  logic       quad_a;
  logic       quad_b;
  logic [7:0] pos;
  logic       dir;
  logic       step;
  logic       err;

  int total;
  int bad;
  int stepSeen;

  quad_decoder #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clear (clear),
    .quad_a(quad_a),
    .quad_b(quad_b),
    .pos   (pos),
    .dir   (dir),
    .step  (step),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a new phase at a falling edge, then watch n falling edges counting step pulses.
  task automatic applyStimulus(input logic a, input logic b, input int n);
    @(negedge clk);
    quad_a   = a;
    quad_b   = b;
    stepSeen = 0;
    repeat (n) begin
      @(negedge clk);
      if (step === 1'b1) stepSeen++;
    end
  endtask

  task automatic pulseClear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic releaseReset(input logic a, input logic b);
    @(negedge clk);
    reset  = 1'b0;
    quad_a = a;
    quad_b = b;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    total++;
    if ({pos, dir, step, err} !== 11'b0) begin
      bad++;
      $display("[TB] FAIL reset_async: got pos=%0d dir=%b step=%b err=%b, want all 0", pos, dir, step, err);
    end
    releaseReset(1'b0, 1'b0);
    total++;
    if (pos !== 8'd0 || err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_release: got pos=%0d err=%b, want pos=0 err=0", pos, err);
    end
  endtask

  task automatic test_forward();
    logic [1:0] seq [4];
    int pulses;
    int badPulse;
    seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b10; seq[3] = 2'b00;
    pulses   = 0;
    badPulse = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(seq[i % 4][1], seq[i % 4][0], 4);
      pulses += stepSeen;
      if (stepSeen != 1) badPulse++;
    end
    total++;
    if (pos !== 8'd16) begin
      bad++;
      $display("[TB] FAIL fwd_pos: got %0d, want 16", pos);
    end
    total++;
    if (dir !== 1'b1) begin
      bad++;
      $display("[TB] FAIL fwd_dir: got %b, want 1", dir);
    end
    total++;
    if (pulses != 16 || badPulse != 0) begin
      bad++;
      $display("[TB] FAIL fwd_steps: got %0d pulses (%0d windows off), want 16 (0)", pulses, badPulse);
    end
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL fwd_err: got %b, want 0", err);
    end
  endtask

  task automatic test_reverse_wrap();
    pulseClear();
    total++;
    if (pos !== 8'd0) begin
      bad++;
      $display("[TB] FAIL rev_clear: got %0d, want 0", pos);
    end
    applyStimulus(1'b1, 1'b0, 4);
    total++;
    if (pos !== 8'd255 || dir !== 1'b0 || stepSeen != 1) begin
      bad++;
      $display("[TB] FAIL rev_wrap: got pos=%0d dir=%b steps=%0d, want pos=255 dir=0 steps=1", pos, dir, stepSeen);
    end
    applyStimulus(1'b1, 1'b1, 4);
    applyStimulus(1'b0, 1'b1, 4);
    applyStimulus(1'b0, 1'b0, 4);
    total++;
    if (pos !== 8'd252 || dir !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rev_more: got pos=%0d dir=%b, want pos=252 dir=0", pos, dir);
    end
  endtask

  task automatic test_illegal();
    applyStimulus(1'b1, 1'b1, 4);
    total++;
    if (err !== 1'b1 || pos !== 8'd252 || dir !== 1'b0 || stepSeen != 0) begin
      bad++;
      $display("[TB] FAIL illegal: got err=%b pos=%0d dir=%b steps=%0d, want err=1 pos=252 dir=0 steps=0",
               err, pos, dir, stepSeen);
    end
    pulseClear();
    total++;
    if (err !== 1'b0 || pos !== 8'd0) begin
      bad++;
      $display("[TB] FAIL illegal_clear: got err=%b pos=%0d, want err=0 pos=0", err, pos);
    end
  endtask

  task automatic test_init_high();
    releaseReset(1'b1, 1'b1);
    total++;
    if (err !== 1'b0 || pos !== 8'd0) begin
      bad++;
      $display("[TB] FAIL init_high: got err=%b pos=%0d, want err=0 pos=0", err, pos);
    end
    applyStimulus(1'b1, 1'b0, 4);
    total++;
    if (pos !== 8'd1 || err !== 1'b0 || stepSeen != 1 || dir !== 1'b1) begin
      bad++;
      $display("[TB] FAIL init_step: got pos=%0d err=%b steps=%0d dir=%b, want pos=1 err=0 steps=1 dir=1",
               pos, err, stepSeen, dir);
    end
  endtask

  task automatic test_clear_collision();
    int pulses;
    pulses = 0;
    @(negedge clk);
    quad_a = 1'b0;
    quad_b = 1'b0;
    @(negedge clk);
    if (step === 1'b1) pulses++;
    @(negedge clk);
    if (step === 1'b1) pulses++;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    if (step === 1'b1) pulses++;
    total++;
    if (pos !== 8'd0 || step !== 1'b0) begin
      bad++;
      $display("[TB] FAIL clear_collide: got pos=%0d step=%b, want pos=0 step=0", pos, step);
    end
    repeat (2) begin
      @(negedge clk);
      if (step === 1'b1) pulses++;
    end
    total++;
    if (pulses != 0 || pos !== 8'd0) begin
      bad++;
      $display("[TB] FAIL clear_nostep: got %0d pulses pos=%0d, want 0 pulses pos=0", pulses, pos);
    end
    en = 1'b0;
    applyStimulus(1'b0, 1'b1, 4);
    pulses = stepSeen;
    applyStimulus(1'b1, 1'b1, 4);
    pulses += stepSeen;
    applyStimulus(1'b1, 1'b0, 4);
    pulses += stepSeen;
    total++;
    if (pos !== 8'd0 || pulses != 0 || err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL en_hold: got pos=%0d pulses=%0d err=%b, want pos=0 pulses=0 err=0", pos, pulses, err);
    end
    en = 1'b1;
    applyStimulus(1'b0, 1'b0, 4);
    total++;
    if (pos !== 8'd1 || err !== 1'b0 || stepSeen != 1) begin
      bad++;
      $display("[TB] FAIL en_resume: got pos=%0d err=%b steps=%0d, want pos=1 err=0 steps=1", pos, err, stepSeen);
    end
  endtask

  task automatic test_reset_mid();
    applyStimulus(1'b0, 1'b1, 4);
    applyStimulus(1'b1, 1'b0, 4);
    total++;
    if (pos !== 8'd2 || err !== 1'b1 || dir !== 1'b1) begin
      bad++;
      $display("[TB] FAIL pre_reset: got pos=%0d err=%b dir=%b, want pos=2 err=1 dir=1", pos, err, dir);
    end
    applyStimulus(1'b1, 1'b1, 1);
    #1 reset = 1'b0;
    #1;
    total++;
    if ({pos, dir, step, err} !== 11'b0) begin
      bad++;
      $display("[TB] FAIL reset_mid: got pos=%0d dir=%b step=%b err=%b, want all 0", pos, dir, step, err);
    end
    repeat (3) @(negedge clk);
    total++;
    if ({pos, dir, step, err} !== 11'b0) begin
      bad++;
      $display("[TB] FAIL reset_hold: got pos=%0d dir=%b step=%b err=%b, want all 0", pos, dir, step, err);
    end
    reset = 1'b1;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    reset  = 1'b1;
    en     = 1'b1;
    clear  = 1'b0;
    quad_a = 1'b0;
    quad_b = 1'b0;
    test_reset();
    test_forward();
    test_reverse_wrap();
    test_illegal();
    test_init_high();
    test_clear_collision();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
